// File: rtl/imem_loader.sv
// Serial boot loader: frames a byte stream (SYNC, LEN, data, CHK) into big-endian
// 32-bit words and writes them to the instruction memory while holding the CPU in reset.
module imem_loader #(
    parameter int unsigned ADDR_W    = 6,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 100000
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [31:0]       ram_a,
    output logic [31:0]       d_t_ram,
    output logic              wram,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned       CNT_W    = ADDR_W + 1;
    localparam int unsigned       TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  DEPTH    = CNT_W'(1 << ADDR_W);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_WR_SETUP, S_WR_PULSE, S_CHK
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [7:0]         xor_q, xor_d;
    logic [31:0]        word_q, word_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               pend_q, pend_d;
    logic [7:0]         pend_byte_q, pend_byte_d;
    logic [31:0]        ram_a_q, ram_a_d;
    logic [31:0]        d_t_ram_q, d_t_ram_d;
    logic               wram_q, wram_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   words_loaded_q, words_loaded_d;

    // A byte caught during the two write cycles is parked and consumed on return.
    logic       in_valid;
    logic [7:0] in_byte;
    logic       counting;
    logic       timeout;
    logic       last_word;

    assign in_valid  = rx_valid | pend_q;
    assign in_byte   = pend_q ? pend_byte_q : rx_data;
    assign counting  = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
    assign timeout   = counting && !in_valid && (tmo_q == TMO_LAST);
    assign last_word = ((words_loaded_q + CNT_ONE) == n_q);

    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (rx_valid && rx_data == SYNC_BYTE) state_d = S_LEN;
            S_LEN:      if (in_valid) state_d = S_DATA;
                        else if (timeout) state_d = S_IDLE;
            S_DATA:     if (in_valid && byte_cnt_q == 2'd3) state_d = S_WR_SETUP;
                        else if (timeout) state_d = S_IDLE;
            S_WR_SETUP: state_d = S_WR_PULSE;
            S_WR_PULSE: state_d = last_word ? S_CHK : S_DATA;
            S_CHK:      if (in_valid || timeout) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // NOTE: every variable gets its hold value first, so no path through this block infers a latch.
    always_comb begin
        n_d            = n_q;
        byte_cnt_d     = byte_cnt_q;
        xor_d          = xor_q;
        word_d         = word_q;
        pend_d         = pend_q;
        pend_byte_d    = pend_byte_q;
        ram_a_d        = ram_a_q;
        d_t_ram_d      = d_t_ram_q;
        cpu_hold_d     = cpu_hold_q;
        done_d         = done_q;
        err_d          = err_q;
        words_loaded_d = words_loaded_q;
        tmo_d          = (rx_valid || !counting) ? '0 : tmo_q + TMO_ONE;

        unique case (state_q)
            S_IDLE: begin
                pend_d = 1'b0;
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    cpu_hold_d     = 1'b1;
                    done_d         = 1'b0;
                    err_d          = 1'b0;
                    words_loaded_d = '0;
                end
            end
            S_LEN: begin
                if (in_valid) begin
                    if (in_byte == 8'd0 || 32'(in_byte) > 32'(DEPTH)) n_d = DEPTH;
                    else                                               n_d = CNT_W'(in_byte);
                    byte_cnt_d = 2'd0;
                    xor_d      = 8'd0;
                end
            end
            S_DATA: begin
                if (in_valid) begin
                    pend_d     = 1'b0;
                    word_d     = {word_q[23:0], in_byte};
                    xor_d      = xor_q ^ in_byte;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        ram_a_d   = 32'({words_loaded_q[ADDR_W-1:0], 2'b00});
                        d_t_ram_d = word_d;
                    end
                end
            end
            S_WR_SETUP, S_WR_PULSE: begin
                if (rx_valid) begin
                    pend_d      = 1'b1;
                    pend_byte_d = rx_data;
                end
                if (state_q == S_WR_PULSE) words_loaded_d = words_loaded_q + CNT_ONE;
            end
            S_CHK: begin
                if (in_valid) begin
                    pend_d     = 1'b0;
                    done_d     = (in_byte == xor_q);
                    err_d      = (in_byte != xor_q);
                    cpu_hold_d = 1'b0;
                end
            end
            default: ;
        endcase

        if (timeout) begin
            err_d      = 1'b1;
            cpu_hold_d = 1'b0;
        end
    end

    // wram is registered off the next state so it rises exactly one cycle after address/data.
    assign wram_d = (state_d == S_WR_PULSE);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            n_q            <= '0;
            byte_cnt_q     <= '0;
            xor_q          <= '0;
            word_q         <= '0;
            tmo_q          <= '0;
            pend_q         <= 1'b0;
            pend_byte_q    <= '0;
            ram_a_q        <= '0;
            d_t_ram_q      <= '0;
            wram_q         <= 1'b0;
            cpu_hold_q     <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            n_q            <= n_d;
            byte_cnt_q     <= byte_cnt_d;
            xor_q          <= xor_d;
            word_q         <= word_d;
            tmo_q          <= tmo_d;
            pend_q         <= pend_d;
            pend_byte_q    <= pend_byte_d;
            ram_a_q        <= ram_a_d;
            d_t_ram_q      <= d_t_ram_d;
            wram_q         <= wram_d;
            cpu_hold_q     <= cpu_hold_d;
            done_q         <= done_d;
            err_q          <= err_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign ram_a        = ram_a_q;
    assign d_t_ram      = d_t_ram_q;
    assign wram         = wram_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_loaded_q;

endmodule
